// File: rtl/sensor_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sensor_sequencer
// Purpose  : Periodic DHT11 read -> UART metrics frame -> LCD refresh scheduler
// Revision : 1.0
// ============================================================================
module sensor_sequencer #(
    parameter int unsigned PERIOD_CYC      = 1_000_000,
    parameter int unsigned DHT_TIMEOUT_CYC = 50_000,
    parameter int unsigned TX_TIMEOUT_CYC  = 200_000,
    parameter int unsigned MAX_RETRY       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       dht_en,
    input  logic       dht_data_ready,
    input  logic [7:0] temperature,
    input  logic [7:0] humidity,
    output logic [7:0] temp_out,
    output logic [7:0] hum_out,
    output logic       sample_valid,
    output logic       en_tx,
    input  logic       tx_msg_done,
    output logic       lcd_en,
    output logic       sensor_fault,
    output logic       overrun,
    output logic [7:0] err_count
);

    localparam int unsigned C_PER_W   = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int unsigned C_TMO_MAX = (DHT_TIMEOUT_CYC > TX_TIMEOUT_CYC) ?
                                        DHT_TIMEOUT_CYC : TX_TIMEOUT_CYC;
    localparam int unsigned C_TMO_W   = (C_TMO_MAX > 1) ? $clog2(C_TMO_MAX) : 1;

    localparam logic [C_PER_W-1:0] C_PER_LAST  = C_PER_W'(PERIOD_CYC - 1);
    localparam logic [C_PER_W-1:0] C_PER_ONE   = C_PER_W'(1);
    localparam logic [C_TMO_W-1:0] C_DHT_LAST  = C_TMO_W'(DHT_TIMEOUT_CYC - 1);
    localparam logic [C_TMO_W-1:0] C_TX_LAST   = C_TMO_W'(TX_TIMEOUT_CYC - 1);
    localparam logic [C_TMO_W-1:0] C_TMO_ONE   = C_TMO_W'(1);
    localparam logic [2:0]         C_RETRY_MAX = 3'(MAX_RETRY);

    localparam logic [2:0] C_IDLE     = 3'd0;
    localparam logic [2:0] C_DHT_WAIT = 3'd1;
    localparam logic [2:0] C_DHT_GAP  = 3'd2;
    localparam logic [2:0] C_TX_WAIT  = 3'd3;
    localparam logic [2:0] C_LCD      = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [C_PER_W-1:0] per_cnt_q, per_cnt_d;
    logic [C_TMO_W-1:0] tmo_q, tmo_d;
    logic [2:0]         retry_q, retry_d;
    logic               dht_en_q, dht_en_d;
    logic               en_tx_q, en_tx_d;
    logic               lcd_en_q, lcd_en_d;
    logic               sample_valid_q, sample_valid_d;
    logic [7:0]         temp_q, temp_d;
    logic [7:0]         hum_q, hum_d;
    logic               fault_q, fault_d;
    logic               overrun_q, overrun_d;
    logic [7:0]         err_q, err_d;

    logic w_tick;
    logic w_busy;
    logic w_err_inc;

    assign w_tick = enable && (per_cnt_q == C_PER_LAST);
    assign w_busy = (state_q != C_IDLE);

    always_comb begin
        state_d        = state_q;
        per_cnt_d      = (!enable || w_tick) ? '0 : per_cnt_q + C_PER_ONE;
        tmo_d          = '0;
        retry_d        = retry_q;
        sample_valid_d = 1'b0;
        temp_d         = temp_q;
        hum_d          = hum_q;
        fault_d        = fault_q;
        overrun_d      = overrun_q | (w_tick & w_busy);
        w_err_inc      = 1'b0;

        // Timeout counters only count while staying in a wait state, so any
        // transition leaves them at zero for the next state.
        case (state_q)
            C_IDLE: begin
                if (w_tick) begin
                    state_d = C_DHT_WAIT;
                    retry_d = '0;
                end
            end
            C_DHT_WAIT: begin
                if (dht_data_ready) begin
                    temp_d         = temperature;
                    hum_d          = humidity;
                    sample_valid_d = 1'b1;
                    fault_d        = 1'b0;
                    state_d        = C_TX_WAIT;
                end else if (tmo_q == C_DHT_LAST) begin
                    w_err_inc = 1'b1;
                    if (retry_q < C_RETRY_MAX) begin
                        retry_d = retry_q + 3'd1;
                        state_d = C_DHT_GAP;
                    end else begin
                        fault_d = 1'b1;
                        state_d = C_LCD;
                    end
                end else begin
                    tmo_d = tmo_q + C_TMO_ONE;
                end
            end
            C_DHT_GAP: begin
                state_d = C_DHT_WAIT;
            end
            C_TX_WAIT: begin
                if (tx_msg_done) begin
                    state_d = C_LCD;
                end else if (tmo_q == C_TX_LAST) begin
                    w_err_inc = 1'b1;
                    state_d   = C_LCD;
                end else begin
                    tmo_d = tmo_q + C_TMO_ONE;
                end
            end
            C_LCD: begin
                state_d = C_IDLE;
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase

        // Dropping enable abandons the sequence but keeps the sample history.
        if (!enable) begin
            state_d        = C_IDLE;
            tmo_d          = '0;
            retry_d        = '0;
            sample_valid_d = 1'b0;
            temp_d         = temp_q;
            hum_d          = hum_q;
            fault_d        = fault_q;
            w_err_inc      = 1'b0;
        end

        err_d    = (w_err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
        dht_en_d = (state_d == C_DHT_WAIT);
        en_tx_d  = (state_d == C_TX_WAIT);
        lcd_en_d = (state_d == C_LCD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= C_IDLE;
            per_cnt_q      <= '0;
            tmo_q          <= '0;
            retry_q        <= '0;
            dht_en_q       <= 1'b0;
            en_tx_q        <= 1'b0;
            lcd_en_q       <= 1'b0;
            sample_valid_q <= 1'b0;
            temp_q         <= 8'd0;
            hum_q          <= 8'd0;
            fault_q        <= 1'b0;
            overrun_q      <= 1'b0;
            err_q          <= 8'd0;
        end else begin
            state_q        <= state_d;
            per_cnt_q      <= per_cnt_d;
            tmo_q          <= tmo_d;
            retry_q        <= retry_d;
            dht_en_q       <= dht_en_d;
            en_tx_q        <= en_tx_d;
            lcd_en_q       <= lcd_en_d;
            sample_valid_q <= sample_valid_d;
            temp_q         <= temp_d;
            hum_q          <= hum_d;
            fault_q        <= fault_d;
            overrun_q      <= overrun_d;
            err_q          <= err_d;
        end
    end

    assign dht_en       = dht_en_q;
    assign en_tx        = en_tx_q;
    assign lcd_en       = lcd_en_q;
    assign sample_valid = sample_valid_q;
    assign temp_out     = temp_q;
    assign hum_out      = hum_q;
    assign sensor_fault = fault_q;
    assign overrun      = overrun_q;
    assign err_count    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sensor_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sensor_sequencer
// Purpose  : Timeline reference model for sensor_sequencer with planned/random sample sequences
// Revision : 1.0
// ============================================================================
module tb_sensor_sequencer;

    localparam int P_CYC = 100;
    localparam int DTO   = 30;
    localparam int TTO   = 50;
    localparam int MR    = 2;
    localparam int NATT  = MR + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, enable, dht_data_ready, tx_msg_done;
    logic [7:0] temperature, humidity;
    logic       dht_en, sample_valid, en_tx, lcd_en, sensor_fault, overrun;
    logic [7:0] temp_out, hum_out, err_count;

    sensor_sequencer #(
        .PERIOD_CYC     (P_CYC),
        .DHT_TIMEOUT_CYC(DTO),
        .TX_TIMEOUT_CYC (TTO),
        .MAX_RETRY      (MR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .dht_en        (dht_en),
        .dht_data_ready(dht_data_ready),
        .temperature   (temperature),
        .humidity      (humidity),
        .temp_out      (temp_out),
        .hum_out       (hum_out),
        .sample_valid  (sample_valid),
        .en_tx         (en_tx),
        .tx_msg_done   (tx_msg_done),
        .lcd_en        (lcd_en),
        .sensor_fault  (sensor_fault),
        .overrun       (overrun),
        .err_count     (err_count)
    );

    int checks   = 0;
    int failures = 0;

    // Model: m_si is the cycle index inside the running sequence (-1 = idle),
    // m_ecnt is the period position of the current cycle.
    int         m_si, m_ecnt, m_err;
    logic [7:0] m_temp, m_hum;
    bit         m_fault, m_ovr;

    // Plan of the running sequence (c_*) and of the next one to start (n_*).
    // A DHT delay >= DTO means that attempt never sees ready.
    int         c_d [NATT];
    int         c_txd, c_acc, c_r, c_l, c_txlen;
    bit         c_txerr;
    logic [7:0] c_t, c_h;
    int         n_d [NATT];
    int         n_txd;
    logic [7:0] n_t, n_h;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_si    = -1;
        m_ecnt  = 0;
        m_err   = 0;
        m_temp  = 8'd0;
        m_hum   = 8'd0;
        m_fault = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic set_plan(input int d0, input int d1, input int d2, input int txd,
                            input logic [7:0] t, input logic [7:0] h);
        n_d[0] = d0;
        n_d[1] = d1;
        n_d[2] = d2;
        n_txd  = txd;
        n_t    = t;
        n_h    = h;
    endtask

    // Attempt k occupies [k*(DTO+1), k*(DTO+1)+DTO-1]; ready at R is accepted,
    // TX covers R+1..R+txlen and the LCD pulse lands right after.
    task automatic load_plan();
        for (int k = 0; k < NATT; k++) c_d[k] = n_d[k];
        c_txd = n_txd;
        c_t   = n_t;
        c_h   = n_h;
        c_acc = -1;
        for (int k = 0; k < NATT; k++)
            if (c_acc < 0 && c_d[k] < DTO) c_acc = k;
        if (c_acc >= 0) begin
            c_r     = c_acc * (DTO + 1) + c_d[c_acc];
            c_txerr = (c_txd >= TTO);
            c_txlen = c_txerr ? TTO : c_txd + 1;
            c_l     = c_r + 1 + c_txlen;
        end else begin
            c_r     = -10;
            c_txerr = 1'b0;
            c_txlen = 0;
            c_l     = NATT * (DTO + 1) - 1;
        end
    endtask

    function automatic bit exp_dht(input int i);
        int last;
        int a;
        int e;
        bit hit;
        hit  = 1'b0;
        last = (c_acc >= 0) ? c_acc : NATT - 1;
        for (int k = 0; k < NATT; k++) begin
            if (k <= last) begin
                a = k * (DTO + 1);
                e = (k == c_acc) ? a + c_d[k] : a + DTO - 1;
                if (i >= a && i <= e) hit = 1'b1;
            end
        end
        return hit;
    endfunction

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_adv();
        bit tick;
        int j;
        int nxt;
        if (!enable) begin
            m_si   = -1;
            m_ecnt = 0;
        end else begin
            tick = (m_ecnt == P_CYC - 1);
            nxt  = -1;
            if (m_si >= 0 && m_si < c_l) begin
                j   = m_si + 1;
                nxt = j;
                for (int k = 0; k < NATT; k++)
                    if ((c_acc < 0 || k < c_acc) && j == k * (DTO + 1) + DTO) bump_err();
                if (c_acc >= 0 && j == c_r + 1) begin
                    m_temp  = c_t;
                    m_hum   = c_h;
                    m_fault = 1'b0;
                end
                if (j == c_l) begin
                    if (c_txerr) bump_err();
                    if (c_acc < 0) m_fault = 1'b1;
                end
            end
            if (tick) begin
                if (m_si >= 0) begin
                    m_ovr = 1'b1;
                end else begin
                    load_plan();
                    nxt = 0;
                end
            end
            m_si   = nxt;
            m_ecnt = tick ? 0 : m_ecnt + 1;
        end
    endtask

    // Check the current cycle, drive this cycle's inputs, advance one clock.
    task automatic step();
        int i;
        bit act;
        i   = m_si;
        act = (i >= 0);
        chk("dht_en",       32'(dht_en),       32'(act && exp_dht(i)));
        chk("en_tx",        32'(en_tx),        32'(act && c_acc >= 0 && i >= c_r + 1 && i <= c_r + c_txlen));
        chk("lcd_en",       32'(lcd_en),       32'(act && i == c_l));
        chk("sample_valid", 32'(sample_valid), 32'(act && c_acc >= 0 && i == c_r + 1));
        chk("temp_out",     32'(temp_out),     32'(m_temp));
        chk("hum_out",      32'(hum_out),      32'(m_hum));
        chk("sensor_fault", 32'(sensor_fault), 32'(m_fault));
        chk("overrun",      32'(overrun),      32'(m_ovr));
        chk("err_count",    32'(err_count),    32'(m_err));
        dht_data_ready = act && c_acc >= 0 && i == c_r;
        temperature    = dht_data_ready ? c_t : 8'($urandom);
        humidity       = dht_data_ready ? c_h : 8'($urandom);
        tx_msg_done    = act && c_acc >= 0 && !c_txerr && i == c_r + 1 + c_txd;
        model_adv();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input int d0, input int d1, input int d2, input int txd,
                           input logic [7:0] t, input logic [7:0] h);
        bit started;
        bit done;
        set_plan(d0, d1, d2, txd, t, h);
        started = 1'b0;
        done    = 1'b0;
        for (int n = 0; n < 4 * P_CYC && !done; n++) begin
            step();
            if (m_si >= 0) started = 1'b1;
            else if (started) done = 1'b1;
        end
    endtask

    initial begin
        int cnt;
        rst_n          = 1'b0;
        enable         = 1'b0;
        dht_data_ready = 1'b0;
        tx_msg_done    = 1'b0;
        temperature    = 8'd0;
        humidity       = 8'd0;
        model_reset();
        set_plan(99, 99, 99, 0, 8'd0, 8'd0);
        load_plan();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dht_en",  32'(dht_en),    32'd0);
        chk("rst_en_tx",   32'(en_tx),     32'd0);
        chk("rst_lcd_en",  32'(lcd_en),    32'd0);
        chk("rst_temp",    32'(temp_out),  32'd0);
        chk("rst_err",     32'(err_count), 32'd0);
        rst_n = 1'b1;
        step();
        step();
        enable = 1'b1;

        // Nominal sample: ready after 10 cycles, UART done after 20.
        run_seq(10, 99, 99, 20, 8'd25, 8'd40);
        chk("A_temp", 32'(temp_out),  32'd25);
        chk("A_hum",  32'(hum_out),   32'd40);
        chk("A_err",  32'(err_count), 32'd0);

        // Sensor never answers: three windows, then fault and LCD only.
        run_seq(99, 99, 99, 0, 8'd1, 8'd2);
        chk("B_err",   32'(err_count),    32'd3);
        chk("B_fault", 32'(sensor_fault), 32'd1);
        chk("B_temp",  32'(temp_out),     32'd25);

        // Ready lands on the timeout cycle.
        run_seq(DTO - 1, 99, 99, 5, 8'd30, 8'd55);
        chk("C_err",   32'(err_count),    32'd3);
        chk("C_temp",  32'(temp_out),     32'd30);
        chk("C_fault", 32'(sensor_fault), 32'd0);

        // UART never completes.
        run_seq(3, 99, 99, TTO + 20, 8'd12, 8'd60);
        chk("D_err", 32'(err_count), 32'd4);

        // Two retries plus a TX timeout outlast the period.
        run_seq(DTO + 5, DTO + 5, 20, TTO + 5, 8'd7, 8'd9);
        chk("E_ovr", 32'(overrun),   32'd1);
        chk("E_err", 32'(err_count), 32'd7);

        for (int n = 0; n < 30; n++)
            run_seq($urandom_range(0, DTO + 12), $urandom_range(0, DTO + 12),
                    $urandom_range(0, DTO + 12), $urandom_range(0, TTO + 15),
                    8'($urandom), 8'($urandom));

        for (int n = 0; n < 100 && m_err < 255; n++)
            run_seq(99, 99, 99, 0, 8'd3, 8'd4);
        run_seq(99, 99, 99, 0, 8'd5, 8'd6);
        chk("sat_err", 32'(err_count), 32'd255);

        // Enable drops mid DHT wait.
        set_plan(99, 99, 99, 0, 8'd0, 8'd0);
        for (int n = 0; n < 4 * P_CYC && m_si != 5; n++) step();
        enable = 1'b0;
        step();
        step();
        chk("drop_dht_en", 32'(dht_en),    32'd0);
        chk("drop_err",    32'(err_count), 32'd255);
        step();
        enable = 1'b1;
        run_seq(4, 99, 99, 6, 8'h44, 8'h55);
        chk("drop_temp", 32'(temp_out), 32'h44);

        // Asynchronous reset in the middle of the UART handshake.
        set_plan(5, 99, 99, TTO + 10, 8'h11, 8'h22);
        for (int n = 0; n < 4 * P_CYC && !(m_si >= 0 && c_acc >= 0 && m_si == c_r + 10); n++) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_en_tx", 32'(en_tx),        32'd0);
        chk("arst_dht",   32'(dht_en),       32'd0);
        chk("arst_temp",  32'(temp_out),     32'd0);
        chk("arst_hum",   32'(hum_out),      32'd0);
        chk("arst_fault", 32'(sensor_fault), 32'd0);
        chk("arst_ovr",   32'(overrun),      32'd0);
        chk("arst_err",   32'(err_count),    32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt   = 0;
        while (dht_en !== 1'b1 && cnt < 3 * P_CYC) begin
            step();
            cnt++;
        end
        chk("arst_first_dht", 32'(cnt), 32'(P_CYC));
        for (int n = 0; n < 4 * P_CYC && m_si >= 0; n++) step();
        chk("arst_seq_temp", 32'(temp_out),  32'h11);
        chk("arst_seq_err",  32'(err_count), 32'd1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
